// File: rtl/irb_scan_out.sv
// Captures the LCD controller's 8x8 IRB frame and streams it out over valid/ready
// on the rising edge of done, with coordinates, a last flag and a running checksum.
module irb_scan_out #(
    parameter int SCAN_ORDER = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irb_rw,
    input  logic [5:0]  irb_a,
    input  logic [7:0]  irb_d,
    input  logic        done,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_data,
    output logic [2:0]  pix_x,
    output logic [2:0]  pix_y,
    output logic        pix_last,
    output logic [13:0] checksum,
    output logic        checksum_valid,
    output logic        frame_incomplete,
    output logic        wr_err
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  mem_q [64];
    logic [63:0] mask_q;
    logic [63:0] mask_d;
    logic        done_q;
    logic [5:0]  idx_q;
    logic [13:0] checksum_q;
    logic        checksum_valid_q;
    logic        frame_incomplete_q;
    logic        wr_err_q;

    logic        scan_active;
    logic        wr_commit;
    logic        pix_fire;
    logic [5:0]  scan_addr;
    logic [7:0]  cur_pix;

    assign scan_active = (state_q == ST_SCAN);
    assign wr_commit   = (state_q == ST_COLLECT) && !irb_rw;
    assign pix_fire    = scan_active && pix_ready;

    // Column-major order walks x in the outer loop, so index bits swap halves.
    if (SCAN_ORDER == 1) begin : g_col_order
        assign scan_addr = {idx_q[2:0], idx_q[5:3]};
    end else begin : g_row_order
        assign scan_addr = idx_q;
    end

    assign cur_pix = mem_q[scan_addr];

    // Mask including this cycle's write, so an edge-cycle write counts as present.
    assign mask_d = wr_commit ? (mask_q | (64'd1 << irb_a)) : mask_q;

    for (genvar gi = 0; gi < 64; gi++) begin : g_mem
        localparam logic [5:0] ENTRY_ADDR = 6'(gi);
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mem_q[gi] <= 8'd0;
            end else if (wr_commit && (irb_a == ENTRY_ADDR)) begin
                mem_q[gi] <= irb_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_COLLECT;
            mask_q             <= '0;
            done_q             <= 1'b0;
            idx_q              <= '0;
            checksum_q         <= '0;
            checksum_valid_q   <= 1'b0;
            frame_incomplete_q <= 1'b0;
            wr_err_q           <= 1'b0;
        end else begin
            done_q <= done;
            case (state_q)
                ST_COLLECT: begin
                    mask_q <= mask_d;
                    if (done && !done_q) begin
                        state_q            <= ST_SCAN;
                        frame_incomplete_q <= ~&mask_d;
                        idx_q              <= '0;
                        checksum_q         <= '0;
                        checksum_valid_q   <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (!irb_rw) begin
                        wr_err_q <= 1'b1;
                    end
                    if (pix_fire) begin
                        checksum_q <= checksum_q + {6'd0, cur_pix};
                        idx_q      <= idx_q + 6'd1;
                        if (idx_q == 6'd63) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    checksum_valid_q <= 1'b1;
                    mask_q           <= '0;
                    state_q          <= ST_COLLECT;
                end
                default: begin
                    state_q <= ST_COLLECT;
                end
            endcase
        end
    end

    assign pix_valid        = scan_active;
    assign pix_data         = scan_active ? cur_pix : 8'd0;
    assign pix_x            = scan_active ? scan_addr[2:0] : 3'd0;
    assign pix_y            = scan_active ? scan_addr[5:3] : 3'd0;
    assign pix_last         = scan_active && (idx_q == 6'd63);
    assign checksum         = checksum_q;
    assign checksum_valid   = checksum_valid_q;
    assign frame_incomplete = frame_incomplete_q;
    assign wr_err           = wr_err_q;

endmodule

// File: tb/tb_irb_scan_out.sv
// Drives raster and column-major instances side by side and checks every
// cycle against a frame model built from address arithmetic and a byte array.
`timescale 1ns/1ps
module tb_irb_scan_out;

    logic clk = 1'b0;
    logic reset, irb_rw, done, pix_ready;
    logic [5:0] irb_a;
    logic [7:0] irb_d;
    logic [1:0] pv, pl, cv, fi, we;
    logic [1:0][7:0]  pd;
    logic [1:0][2:0]  px, py;
    logic [1:0][13:0] cs;

    always #5 clk = ~clk;

    irb_scan_out #(.SCAN_ORDER(0)) u_raster (
        .clk(clk), .reset(reset), .irb_rw(irb_rw), .irb_a(irb_a), .irb_d(irb_d),
        .done(done), .pix_valid(pv[0]), .pix_ready(pix_ready), .pix_data(pd[0]),
        .pix_x(px[0]), .pix_y(py[0]), .pix_last(pl[0]), .checksum(cs[0]),
        .checksum_valid(cv[0]), .frame_incomplete(fi[0]), .wr_err(we[0])
    );

    irb_scan_out #(.SCAN_ORDER(1)) u_column (
        .clk(clk), .reset(reset), .irb_rw(irb_rw), .irb_a(irb_a), .irb_d(irb_d),
        .done(done), .pix_valid(pv[1]), .pix_ready(pix_ready), .pix_data(pd[1]),
        .pix_x(px[1]), .pix_y(py[1]), .pix_last(pl[1]), .checksum(cs[1]),
        .checksum_valid(cv[1]), .frame_incomplete(fi[1]), .wr_err(we[1])
    );

    // Reference model: frame contents, written set and status flags.
    int unsigned m_mem [64];
    bit          m_written [64];
    bit          m_wr_err;
    bit          m_fi;
    bit          m_cv;
    int unsigned m_cs [2];
    int          total = 0;
    int          bad = 0;
    int          frame_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int addr_of(input int order, input int i);
        if (order == 0) return i;
        return (i % 8) * 8 + i / 8;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int a = 0; a < 64; a++) begin
            m_mem[a] = 0;
            m_written[a] = 0;
        end
        m_wr_err = 0;
        m_fi = 0;
        m_cv = 0;
        m_cs[0] = 0;
        m_cs[1] = 0;
    endtask

    task automatic check_status(input string tag, input bit idle);
        for (int k = 0; k < 2; k++) begin
            if (idle) begin
                chk($sformatf("%s_valid%0d", tag, k), pv[k], 0);
                chk($sformatf("%s_data%0d", tag, k), pd[k], 0);
                chk($sformatf("%s_x%0d", tag, k), px[k], 0);
                chk($sformatf("%s_y%0d", tag, k), py[k], 0);
                chk($sformatf("%s_last%0d", tag, k), pl[k], 0);
            end
            chk($sformatf("%s_cs%0d", tag, k), cs[k], m_cs[k]);
            chk($sformatf("%s_cv%0d", tag, k), cv[k], m_cv);
            chk($sformatf("%s_fi%0d", tag, k), fi[k], m_fi);
            chk($sformatf("%s_werr%0d", tag, k), we[k], m_wr_err);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irb_rw = 1'b1;
        done = 1'b0;
        pix_ready = 1'b0;
        model_clear();
        tick();
        tick();
        check_status("reset", 1);
        reset = 1'b0;
        tick();
    endtask

    task automatic wr(input int a, input int d);
        irb_rw = 1'b0;
        irb_a = 6'(a);
        irb_d = 8'(d);
        tick();
        irb_rw = 1'b1;
        m_mem[a] = d;
        m_written[a] = 1;
    endtask

    // ready_mode: 0 always ready, 1 ready on odd cycles, 2 random.
    task automatic run_frame(input int ready_mode, input int wr_at, input int rst_at,
                             input int edge_a, input int edge_d);
        int i, cyc, sum_full;
        bit rdy, injected, all_written;
        injected = 0;
        done = 1'b1;
        pix_ready = 1'($urandom_range(0, 1));
        if (edge_a >= 0) begin
            irb_rw = 1'b0;
            irb_a = 6'(edge_a);
            irb_d = 8'(edge_d);
            m_mem[edge_a] = edge_d;
            m_written[edge_a] = 1;
        end
        all_written = 1;
        sum_full = 0;
        for (int a = 0; a < 64; a++) begin
            if (!m_written[a]) all_written = 0;
            sum_full += m_mem[a];
        end
        m_fi = !all_written;
        m_cv = 0;
        m_cs[0] = 0;
        m_cs[1] = 0;
        tick();
        irb_rw = 1'b1;
        i = 0;
        cyc = 0;
        while (i < 64 && cyc < 2000) begin
            if (i == rst_at) begin
                reset = 1'b1;
                #1;
                model_clear();
                check_status("midreset", 1);
                done = 1'b0;
                pix_ready = 1'b0;
                irb_rw = 1'b1;
                tick();
                reset = 1'b0;
                $display("frame %0d: reset at pixel %0d", frame_no, i);
                frame_no++;
                return;
            end
            for (int k = 0; k < 2; k++) begin
                int a;
                a = addr_of(k, i);
                chk($sformatf("px_valid%0d_%0d", k, i), pv[k], 1);
                chk($sformatf("px_data%0d_%0d", k, i), pd[k], m_mem[a]);
                chk($sformatf("px_x%0d_%0d", k, i), px[k], a % 8);
                chk($sformatf("px_y%0d_%0d", k, i), py[k], a / 8);
                chk($sformatf("px_last%0d_%0d", k, i), pl[k], (i == 63));
            end
            check_status($sformatf("scan_%0d", i), 0);
            case (ready_mode)
                0:       rdy = 1;
                1:       rdy = (cyc % 2) == 1;
                default: rdy = $urandom_range(0, 3) != 0;
            endcase
            pix_ready = rdy;
            if (i == wr_at && !injected) begin
                irb_rw = 1'b0;
                irb_a = 6'd10;
                irb_d = 8'hAA;
                injected = 1;
                m_wr_err = 1;
            end else begin
                irb_rw = 1'b1;
            end
            tick();
            cyc++;
            if (rdy) begin
                m_cs[0] += m_mem[addr_of(0, i)];
                m_cs[1] += m_mem[addr_of(1, i)];
                i++;
            end
        end
        irb_rw = 1'b1;
        chk("scan_pixels", i, 64);
        if (ready_mode == 0) chk("scan_cycles_full", cyc, 64);
        if (ready_mode == 1) chk("scan_cycles_bp", cyc, 128);
        chk("sum_order0", m_cs[0], sum_full);
        check_status("drain", 1);
        m_cv = 1;
        for (int a = 0; a < 64; a++) m_written[a] = 0;
        tick();
        check_status("post", 1);
        tick();
        check_status("held_done", 1);
        $display("frame %0d: order0 cs=%0d order1 cs=%0d fi=%0d wr_err=%0d cycles=%0d",
                 frame_no, cs[0], cs[1], fi[0], we[0], cyc);
        frame_no++;
        done = 1'b0;
        tick();
    endtask

    initial begin
        irb_a = '0;
        irb_d = '0;
        do_reset();

        // Raster / column-major full frame, data = address.
        for (int a = 0; a < 64; a++) wr(a, a);
        run_frame(0, -1, -1, -1, 0);
        chk("cs_2016_r", cs[0], 2016);
        chk("cs_2016_c", cs[1], 2016);

        // Backpressure with all-0xFF frame.
        for (int a = 0; a < 64; a++) wr(a, 8'hFF);
        run_frame(1, -1, -1, -1, 0);
        chk("cs_16320", cs[0], 16320);

        // Incomplete frame after reset.
        do_reset();
        for (int a = 0; a < 63; a++) wr(a, 5);
        run_frame(0, -1, -1, -1, 0);
        chk("fi_set", fi[0], 1);
        chk("cs_315", cs[1], 315);

        // Write during scan at pixel 3 is dropped and sticky.
        do_reset();
        for (int a = 0; a < 64; a++) wr(a, a);
        run_frame(0, 3, -1, -1, 0);
        chk("werr_sticky", we[0], 1);

        // Edge-cycle write completes a frame missing address 63.
        for (int a = 0; a < 63; a++) wr(a, $urandom_range(0, 255));
        run_frame(2, -1, -1, 63, 8'h5A);

        // Random frames: random subsets, values and ready.
        for (int f = 0; f < 4; f++) begin
            int n;
            n = $urandom_range(20, 90);
            for (int w = 0; w < n; w++) wr($urandom_range(0, 63), $urandom_range(0, 255));
            run_frame(2, (f == 1) ? 7 : -1, -1, -1, 0);
        end

        // Reset mid-scan, then a fresh partial load sees cleared memory.
        for (int a = 0; a < 64; a++) wr(a, $urandom_range(1, 255));
        run_frame(0, -1, 20, -1, 0);
        for (int c = 0; c < 3; c++) begin
            pix_ready = 1'b1;
            tick();
            check_status("after_reset", 1);
        end
        for (int a = 0; a < 64; a += 2) wr(a, $urandom_range(0, 255));
        run_frame(2, -1, -1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irb_scan_out.md
# irb_scan_out

Result-buffer sink sitting directly downstream of the LCD controller's IRB write port. It captures the 64 pixel writes (8×8, 8-bit) the controller emits during its WRITE command. On the controller's `done` rising edge it streams the frame out pixel by pixel over a valid/ready handshake, with coordinates, a last flag and a running checksum. It also flags incomplete frames and writes that arrive while a scan is in progress.

## Interface
- `SCAN_ORDER`, default 0: 0 = raster (row-major, y outer); 1 = column-major (x outer).
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `irb_rw`  in  1  0 = write strobe from controller, 1 = idle.
- `irb_a`  in  6  write address, {y[2:0], x[2:0]}.
- `irb_d`  in  8  write data.
- `done`  in  1  controller frame-complete level.
- `pix_valid`  out  1  pixel available.
- `pix_ready`  in  1  consumer accepts pixel.
- `pix_data`  out  8  pixel value.
- `pix_x`, `pix_y`  out  3 each  pixel coordinates.
- `pix_last`  out  1  final pixel of frame.
- `checksum`  out  14  sum of all 64 emitted pixels, unsigned (max 16320).
- `checksum_valid`  out  1  checksum final.
- `frame_incomplete`  out  1  scan started with unwritten addresses.
- `wr_err`  out  1  sticky: write seen during SCAN.

## Operation
- Storage: 64×8 array plus 64-bit written mask. Reset clears both to 0.
- States:
  - COLLECT (reset state).
  - SCAN.
  - DRAIN: one cycle, then back to COLLECT.
- COLLECT:
  - A cycle with `irb_rw`=0 writes `mem[irb_a]`←`irb_d` and sets `mask[irb_a]`.
  - Repeated writes to one address overwrite; last write wins.
  - Edge detect: `done_q` is `done` registered, reset 0.
  - `done`=1 with `done_q`=0 → SCAN next cycle.
  - In that same cycle:
    - any write still commits;
    - `frame_incomplete` ← ~&mask (mask taken including that cycle's write);
    - scan index ← 0, `checksum` ← 0, `checksum_valid` ← 0.
- SCAN:
  - Index i, 6 bits.
  - Address: SCAN_ORDER 0 uses addr = i; SCAN_ORDER 1 uses addr = {i[2:0], i[5:3]}.
  - `pix_valid`=1.
  - `pix_data`=mem[addr], `pix_x`=addr[2:0], `pix_y`=addr[5:3].
  - `pix_last`=(i==63).
  - On handshake (`pix_valid`&`pix_ready`): `checksum` += `pix_data` (zero-extended to 14 bits); i increments.
  - On the handshake with i==63 → DRAIN.
  - Writes (`irb_rw`=0) during SCAN are dropped and set `wr_err`. Memory and mask are unchanged.
  - A `done` edge during SCAN is ignored.
- DRAIN:
  - `checksum_valid` ← 1; mask cleared; → COLLECT.
  - `checksum` and `checksum_valid` hold until the next scan start or reset.
  - Memory contents are retained; new writes overwrite them.
- Outputs when `pix_valid`=0: `pix_data`, `pix_x`, `pix_y` and `pix_last` are driven 0.
- `wr_err` clears only on reset. `frame_incomplete` updates at each scan start.
- Unwritten addresses emit their retained value (0 after reset).
- A new frame needs `done` to fall and rise again. The controller holds `done` high, so this normally means one frame per reset.

## Timing
- Reset values:
  - state COLLECT;
  - all outputs 0;
  - memory, mask and `done_q` 0.
- Reset mid-SCAN: aborts immediately; all outputs 0.
- Write latency: written data is visible to a scan starting the cycle after the write. The write in the edge cycle is included.
- Edge at cycle N → `pix_valid`=1 at N+1, pixel 0 presented.
- Outputs are combinational from registered index/state/memory. Without backpressure, one pixel per cycle.
- Full-rate scan: last handshake at N+64; DRAIN at N+65 (`pix_valid`=0). `checksum_valid`=1 from N+66.
- `pix_ready`=0 stalls; all pixel outputs hold stable while `pix_valid`=1 and `pix_ready`=0.
- `pix_ready` is ignored outside SCAN.

## Test plan
- Raster full frame: write mem[a]=a for a=0..63, pulse `done`, `pix_ready`=1 → 64 pixels 0..63, (x,y)=(a%8,a/8), `pix_last` only on 63, `checksum`=2016, `checksum_valid` at N+66, `frame_incomplete`=0.
- SCAN_ORDER=1, same data → pixel sequence 0,8,16,…,56,1,9,…,63; `checksum`=2016.
- Backpressure: all pixels 0xFF, `pix_ready` toggles 1,0 → each pixel held stable during stall, 128 SCAN cycles, `checksum`=16320 (no overflow).
- Incomplete frame: write only addresses 0..62 (value 5), `done` edge → `frame_incomplete`=1, pixel 63 = 0, `checksum`=315.
- Write during SCAN: `irb_rw`=0, a=10, d=0xAA at pixel 3 → `wr_err`=1 (sticky), pixel 10 keeps the old value.
- Reset mid-scan at pixel 20 → all outputs 0, `pix_valid` stays 0. A fresh load plus `done` edge scans correctly, with memory cleared by the reset.
